mcpu_seq_alu: RTL and testbench
===============================

Name: mcpu_seq_alu

Overview:
Registered, handshaked successor to the combinational MCPU ALU: parametrised word width, an extended opcode set (adds SUB and a multi-cycle MUL), and a valid/ready interface on both operand and result sides. It sits between the MCPU decode stage and the register writeback. The result is held stable until consumed, so downstream can stall.

Parameters:
CMD_SIZE, 3, opcode width; must be >= 3.
WORD_SIZE, 8, operand width in bits; must be >= 2. Result width is 2*WORD_SIZE.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
in_valid  input  1  opcode/r1/r2 valid.
in_ready  output  1  block can accept an operation.
opcode  input  CMD_SIZE  operation select.
r1  input  WORD_SIZE  operand A, unsigned.
r2  input  WORD_SIZE  operand B, unsigned.
out_valid  output  1  out/OVERFLOW valid.
out_ready  input  1  consumer accepts the result.
out  output  2*WORD_SIZE  result.
OVERFLOW  output  1  overflow/borrow flag for the result.

Behaviour:
- Clocking: one clock. Reset is asynchronous and active-low (reset_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out=0, OVERFLOW=0, internal multiplier registers=0.
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 MUL. Opcodes 6 and above execute as ADD, matching the legacy default branch.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture opcode/r1/r2. Go to BUSY if opcode=MUL, else to DONE with the result registered the same edge.
  - BUSY: in_ready=0. Shift-add multiply, one bit of r2 per cycle, exactly WORD_SIZE cycles, then go to DONE with the product registered.
  - DONE: out_valid=1, in_ready=0. out/OVERFLOW are held constant. On out_ready, go to IDLE and drop out_valid the next cycle.
- Latency (accept edge to out_valid high):
  - Non-MUL ops: out_valid is high in the cycle after the accept edge.
  - MUL: out_valid rises WORD_SIZE+1 cycles after the accept edge.
- Throughput: no overlap. A new op is accepted only in IDLE, so back-to-back non-MUL ops take a minimum of 2 cycles each when out_ready is held at 1.
- Result formatting:
  - AND/OR/XOR: low WORD_SIZE bits = r1 op r2; upper bits 0; OVERFLOW=0.
  - ADD: out = zero-extended (WORD_SIZE+1)-bit sum; OVERFLOW = carry out of bit WORD_SIZE-1.
  - SUB: low WORD_SIZE bits = (r1-r2) mod 2^WORD_SIZE; upper bits 0; OVERFLOW = borrow (r1<r2).
  - MUL: out = full unsigned product; OVERFLOW = 1 iff the upper WORD_SIZE bits are nonzero.
- Boundary conditions:
  - in_valid while not IDLE: ignored (in_ready=0). The source must hold its operands.
  - out_ready asserted outside DONE: no effect.
  - Operands change during BUSY: no effect, because operands were captured at accept.
  - MUL by 0 or by 1: still takes the full WORD_SIZE cycles; no early exit.
  - reset_n low in any state: outputs return to reset values immediately, any in-flight op is discarded, and no out_valid is produced for it.

Optional Feature:
MCPU_ALU_SAT_EN
- Defined: ADD and SUB saturate. ADD carry gives low WORD_SIZE bits all-ones with bit WORD_SIZE = 0. SUB borrow gives 0. OVERFLOW is still set in both cases. MUL and logic ops are unchanged.
- Undefined: wrapping/extended results as in Behaviour.

Test Plan:
1. Reset, then opcode=0, r1=8'hF0, r2=8'h3C, out_ready=1 -> out_valid one cycle after accept, out=16'h0030, OVERFLOW=0; then opcodes 1 and 2 -> 16'h00FC, 16'h00CC.
2. ADD r1=8'hFF, r2=8'h01 -> out=16'h0100, OVERFLOW=1. SUB r1=8'h05, r2=8'h07 -> out=16'h00FE, OVERFLOW=1. With MCPU_ALU_SAT_EN defined: ADD -> 16'h00FF, SUB -> 16'h0000, OVERFLOW=1 for both.
3. MUL r1=8'hFF, r2=8'hFF -> in_ready low for 8 BUSY cycles, out_valid 9 cycles after accept, out=16'hFE01, OVERFLOW=1. MUL 8'h0F x 8'h02 -> 16'h001E, OVERFLOW=0.
4. Backpressure: non-MUL result, hold out_ready=0 for 5 cycles while toggling r1/r2/in_valid -> out/OVERFLOW stable, in_ready=0, no new accept. Raise out_ready -> IDLE next cycle, and the next op is accepted.
5. opcode=7, r1=8'h80, r2=8'h80 -> treated as ADD: out=16'h0100, OVERFLOW=1.
6. Pulse reset_n low for 1 cycle in the 4th BUSY cycle of a MUL -> out_valid=0, out=0, in_ready=1 immediately; no result appears for the aborted op, and a following ADD completes normally.

Source files
------------

// File: rtl/mcpu_seq_alu.sv
`default_nettype none
// ============================================================================
// Module  : mcpu_seq_alu
// Brief   : Registered valid/ready MCPU ALU with AND/OR/XOR/ADD/SUB and a
//           shift-add MUL. Optional MCPU_ALU_SAT_EN makes ADD/SUB saturate.
// Revision: 1.0 - initial release
// ============================================================================
module mcpu_seq_alu #(
    parameter int CMD_SIZE  = 3,
    parameter int WORD_SIZE = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CMD_SIZE-1:0]    opcode,
    input  logic [WORD_SIZE-1:0]   r1,
    input  logic [WORD_SIZE-1:0]   r2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WORD_SIZE-1:0] out,
    output logic                   OVERFLOW
);

    localparam int c_W     = WORD_SIZE;
    localparam int c_RW    = 2 * WORD_SIZE;
    localparam int c_CNT_W = $clog2(WORD_SIZE);

    localparam logic [CMD_SIZE-1:0] c_OP_AND = CMD_SIZE'(0);
    localparam logic [CMD_SIZE-1:0] c_OP_OR  = CMD_SIZE'(1);
    localparam logic [CMD_SIZE-1:0] c_OP_XOR = CMD_SIZE'(2);
    localparam logic [CMD_SIZE-1:0] c_OP_SUB = CMD_SIZE'(4);
    localparam logic [CMD_SIZE-1:0] c_OP_MUL = CMD_SIZE'(5);
    localparam logic [c_CNT_W-1:0]  c_LAST   = c_CNT_W'(WORD_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [c_RW-1:0]      r_out;
    logic                 r_overflow;
    logic [c_RW-1:0]      r_mcand;
    logic [c_W-1:0]       r_mplier;
    logic [c_RW-1:0]      r_acc;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [c_W:0]         w_sum;
    logic [c_W:0]         w_diff;
    logic [c_RW-1:0]      w_res;
    logic                 w_ovf;
    logic [c_RW-1:0]      w_partial;

    assign w_sum  = {1'b0, r1} + {1'b0, r2};
    // The extra top bit of the widened difference is the borrow.
    assign w_diff = {1'b0, r1} - {1'b0, r2};

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (opcode)
            c_OP_AND: w_res[c_W-1:0] = r1 & r2;
            c_OP_OR:  w_res[c_W-1:0] = r1 | r2;
            c_OP_XOR: w_res[c_W-1:0] = r1 ^ r2;
            c_OP_SUB: begin
                w_ovf = w_diff[c_W];
`ifdef MCPU_ALU_SAT_EN
                w_res[c_W-1:0] = w_diff[c_W] ? '0 : w_diff[c_W-1:0];
`else
                w_res[c_W-1:0] = w_diff[c_W-1:0];
`endif
            end
            c_OP_MUL: w_res = '0;
            default: begin
                // ADD, also reached by every opcode above MUL
                w_ovf = w_sum[c_W];
`ifdef MCPU_ALU_SAT_EN
                w_res[c_W-1:0] = w_sum[c_W] ? '1 : w_sum[c_W-1:0];
`else
                w_res[c_W:0] = w_sum;
`endif
            end
        endcase
    end

    assign w_partial = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_overflow  <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (opcode == c_OP_MUL) begin
                            r_mcand  <= {{c_W{1'b0}}, r1};
                            r_mplier <= r2;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_state  <= S_BUSY;
                        end else begin
                            r_out       <= w_res;
                            r_overflow  <= w_ovf;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    // One multiplier bit per cycle, always the full word length.
                    r_acc    <= w_partial;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_out       <= w_partial;
                        r_overflow  <= |w_partial[c_RW-1:c_W];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign OVERFLOW  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mcpu_seq_alu.sv
`default_nettype none
// ============================================================================
// Module  : tb_mcpu_seq_alu
// Brief   : Self-checking bench for mcpu_seq_alu: directed vectors plus random
//           traffic compared every cycle against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mcpu_seq_alu;

    localparam int c_CMD = 3;
    localparam int c_W   = 8;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [c_CMD-1:0] opcode;
    logic [c_W-1:0]   r1;
    logic [c_W-1:0]   r2;
    logic             out_valid;
    logic             out_ready;
    logic [2*c_W-1:0] out;
    logic             OVERFLOW;

    int n_cmp = 0;
    int n_bad = 0;

    mcpu_seq_alu #(
        .CMD_SIZE  (c_CMD),
        .WORD_SIZE (c_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .r1        (r1),
        .r2        (r2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .OVERFLOW  (OVERFLOW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, plain arithmetic.
    function automatic void ref_op(input int op, input int a, input int b,
                                   output int res, output bit ov);
        int lim;
        lim = 1 << c_W;
        ov  = 1'b0;
        case (op)
            0: res = a & b;
            1: res = a | b;
            2: res = a ^ b;
            4: begin
                ov  = (a < b);
                res = (a - b + lim) % lim;
`ifdef MCPU_ALU_SAT_EN
                if (ov) res = 0;
`endif
            end
            5: begin
                res = a * b;
                ov  = (res >= lim);
            end
            default: begin
                res = a + b;
                ov  = (res >= lim);
`ifdef MCPU_ALU_SAT_EN
                if (ov) res = lim - 1;
`endif
            end
        endcase
    endfunction

    // Model: phase 0 = accepting, 1 = multiplying, 2 = holding a result.
    int m_phase = 0;
    int m_left  = 0;
    int m_out   = 0;
    bit m_ov    = 1'b0;

    task automatic m_reset();
        m_phase = 0;
        m_left  = 0;
        m_out   = 0;
        m_ov    = 1'b0;
    endtask

    initial begin
        int res;
        bit ov;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_reset();
            end else if (m_phase == 0) begin
                if (in_valid) begin
                    ref_op(int'(opcode), int'(r1), int'(r2), res, ov);
                    m_out = res;
                    m_ov  = ov;
                    if (int'(opcode) == 5) begin
                        m_phase = 1;
                        m_left  = c_W;
                    end else begin
                        m_phase = 2;
                    end
                end
            end else if (m_phase == 1) begin
                m_left--;
                if (m_left == 0) m_phase = 2;
            end else if (out_ready) begin
                m_phase = 0;
            end
            #1;
            if (!reset_n) m_reset();
            chk("model_in_ready", {31'd0, in_ready}, {31'd0, m_phase == 0});
            chk("model_out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
            if (m_phase == 2 || !reset_n) begin
                chk("model_out", {16'd0, out}, m_out);
                chk("model_overflow", {31'd0, OVERFLOW}, {31'd0, m_ov});
            end
        end
    end

    // Issue one op and check its result and latency against literal values.
    task automatic do_op(input int op, input int a, input int b, input bit ordy,
                         input int exp_out, input bit exp_ov, input int exp_lat);
        int n;
        int lat;
        int busy;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        opcode    = c_CMD'(op);
        r1        = c_W'(a);
        r2        = c_W'(b);
        out_ready = ordy;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat  = 1;
        busy = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) busy++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("op_latency", lat, exp_lat);
        chk("op_busy_cycles", busy, (op == 5) ? c_W : 0);
        chk("op_out", {16'd0, out}, exp_out);
        chk("op_overflow", {31'd0, OVERFLOW}, {31'd0, exp_ov});
    endtask

    function automatic logic [c_W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return c_W'(1);
            2:       return '1;
            default: return c_W'($urandom);
        endcase
    endfunction

    initial begin
        logic [2*c_W-1:0] held_out;
        logic             held_ov;
        int               n;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        opcode    = '0;
        r1        = '0;
        r2        = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out", {16'd0, out}, 32'd0);
        chk("reset_overflow", {31'd0, OVERFLOW}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        do_op(0, 'hF0, 'h3C, 1'b1, 'h0030, 1'b0, 1);
        do_op(1, 'hF0, 'h3C, 1'b1, 'h00FC, 1'b0, 1);
        do_op(2, 'hF0, 'h3C, 1'b1, 'h00CC, 1'b0, 1);
`ifdef MCPU_ALU_SAT_EN
        do_op(3, 'hFF, 'h01, 1'b1, 'h00FF, 1'b1, 1);
        do_op(4, 'h05, 'h07, 1'b1, 'h0000, 1'b1, 1);
`else
        do_op(3, 'hFF, 'h01, 1'b1, 'h0100, 1'b1, 1);
        do_op(4, 'h05, 'h07, 1'b1, 'h00FE, 1'b1, 1);
`endif
        do_op(4, 'h07, 'h05, 1'b1, 'h0002, 1'b0, 1);
        do_op(5, 'hFF, 'hFF, 1'b1, 'hFE01, 1'b1, c_W + 1);
        do_op(5, 'h0F, 'h02, 1'b1, 'h001E, 1'b0, c_W + 1);
        do_op(5, 'hA5, 'h00, 1'b1, 'h0000, 1'b0, c_W + 1);
        do_op(5, 'hA5, 'h01, 1'b1, 'h00A5, 1'b0, c_W + 1);
`ifdef MCPU_ALU_SAT_EN
        do_op(7, 'h80, 'h80, 1'b1, 'h00FF, 1'b1, 1);
`else
        do_op(7, 'h80, 'h80, 1'b1, 'h0100, 1'b1, 1);
`endif

        // Backpressure: result must hold while inputs churn.
        do_op(2, 'h5A, 'h0F, 1'b0, 'h0055, 1'b0, 1);
        held_out = out;
        held_ov  = OVERFLOW;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            r1       = c_W'($urandom);
            r2       = c_W'($urandom);
            opcode   = c_CMD'($urandom_range(0, 7));
            @(posedge clk);
            #1;
            chk("bp_out_stable", {16'd0, out}, {16'd0, held_out});
            chk("bp_ovf_stable", {31'd0, OVERFLOW}, {31'd0, held_ov});
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        do_op(0, 'h3C, 'h0F, 1'b1, 'h000C, 1'b0, 1);

        // Abort a MUL in its fourth busy cycle.
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        opcode   = c_CMD'(5);
        r1       = 'hFF;
        r2       = 'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_out", {16'd0, out}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_result", {31'd0, out_valid}, 32'd0);
        end
        do_op(3, 'h12, 'h34, 1'b1, 'h0046, 1'b0, 1);

        // Random traffic, checked by the model process every cycle.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 1) == 1);
            opcode    = c_CMD'($urandom_range(0, 7));
            r1        = pick();
            r2        = pick();
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (c_W + 4) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
